// File: rtl/unidad_muldiv_pkg.sv
// ============================================================================
// unidad_muldiv_pkg : shared constants and FSM state type for the RV32M unit
// Rev 1.0
// ============================================================================
`default_nettype none

package unidad_muldiv_pkg;

  localparam int c_XLEN = 32;

  // RV32M funct3 encoding
  localparam logic [2:0] c_OP_MUL    = 3'd0;
  localparam logic [2:0] c_OP_MULH   = 3'd1;
  localparam logic [2:0] c_OP_MULHSU = 3'd2;
  localparam logic [2:0] c_OP_MULHU  = 3'd3;
  localparam logic [2:0] c_OP_DIV    = 3'd4;
  localparam logic [2:0] c_OP_DIVU   = 3'd5;
  localparam logic [2:0] c_OP_REM    = 3'd6;
  localparam logic [2:0] c_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/unidad_muldiv_corrector_signo.sv
// ============================================================================
// corrector_signo : operand magnitude extraction and result sign correction
// Rev 1.0
// ============================================================================
`default_nettype none

module corrector_signo
  import unidad_muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] mag1_o,
  output logic [31:0] mag2_o,
  output logic        neg_res_o,
  output logic        neg_rem_o,
  input  logic [2:0]  op_cap_i,
  input  logic        neg_res_i,
  input  logic        neg_rem_i,
  input  logic [63:0] acc_i,
  output logic [31:0] result_o
);

  logic        sgn1;
  logic        sgn2;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op_i)
      c_OP_MULH, c_OP_DIV, c_OP_REM: begin
        sgn1 = rs1_i[31];
        sgn2 = rs2_i[31];
      end
      c_OP_MULHSU: sgn1 = rs1_i[31];
      default: ;
    endcase
    mag1_o    = sgn1 ? -rs1_i : rs1_i;
    mag2_o    = sgn2 ? -rs2_i : rs2_i;
    neg_res_o = sgn1 ^ sgn2;
    // Remainder takes the sign of the dividend
    neg_rem_o = sgn1;
  end

  always_comb begin
    prod = neg_res_i ? (~acc_i + 64'd1) : acc_i;
    quo  = neg_res_i ? -acc_i[31:0]  : acc_i[31:0];
    rem  = neg_rem_i ? -acc_i[63:32] : acc_i[63:32];
    unique case (op_cap_i)
      c_OP_MUL:                           result_o = prod[31:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: result_o = prod[63:32];
      c_OP_DIV, c_OP_DIVU:                result_o = quo;
      default:                            result_o = rem;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/unidad_muldiv.sv
// ============================================================================
// unidad_muldiv : 32-cycle iterative RV32M multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

module unidad_muldiv
  import unidad_muldiv_pkg::*;
#(
  parameter int XLEN = c_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] datars1_i,
  input  logic [XLEN-1:0] datars2_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            wren_o
);

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic [2:0]         op_q;
  logic [XLEN-1:0]    mcand_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [2*XLEN-1:0]  acc_d;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [4:0]         rd_cap_q;
  logic [4:0]         rd_q;
  logic [XLEN-1:0]    result_q;
  logic               busy_q;
  logic               done_q;

  logic [XLEN-1:0]    mag1;
  logic [XLEN-1:0]    mag2;
  logic               neg_res;
  logic               neg_rem;
  logic [XLEN-1:0]    res_corr;
  logic               div_zero;
  logic               div_ovf;
  logic [XLEN-1:0]    res_special;
  logic               sub_ok;
  logic [XLEN-1:0]    sub_diff;
  logic [XLEN:0]      add_sum;

  // Sign correction sees the post-step accumulator so the final step and the
  // negate land in the same edge that enters DONE.
  corrector_signo u_corrector_signo (
    .op_i      (op_i),
    .rs1_i     (datars1_i),
    .rs2_i     (datars2_i),
    .mag1_o    (mag1),
    .mag2_o    (mag2),
    .neg_res_o (neg_res),
    .neg_rem_o (neg_rem),
    .op_cap_i  (op_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .acc_i     (acc_d),
    .result_o  (res_corr)
  );

  always_comb begin
    div_zero    = op_i[2] && (datars2_i == '0);
    div_ovf     = ((op_i == c_OP_DIV) || (op_i == c_OP_REM)) &&
                  (datars1_i == 32'h8000_0000) && (datars2_i == 32'hFFFF_FFFF);
    res_special = '0;
    if (div_zero)
      res_special = op_i[1] ? datars1_i : '1;
    else if (div_ovf)
      res_special = op_i[1] ? '0 : 32'h8000_0000;
  end

  // Divide: acc = {remainder, quotient}; multiply: acc = {partial, multiplier}
  always_comb begin
    sub_ok   = (acc_q[63:31] >= {1'b0, mcand_q});
    sub_diff = acc_q[62:31] - mcand_q;
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    if (op_q[2])
      acc_d = sub_ok ? {sub_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    else
      acc_d = {add_sum, acc_q[31:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_cap_q  <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            rd_cap_q  <= rd_i;
            cnt_q     <= '0;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            busy_q    <= 1'b1;
            if (div_zero || div_ovf) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= res_special;
              rd_q     <= rd_i;
            end else begin
              state_q <= ST_CALC;
              acc_q   <= op_i[2] ? {32'd0, mag1} : {32'd0, mag2};
              mcand_q <= op_i[2] ? mag2 : mag1;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= res_corr;
            rd_q     <= rd_cap_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign wren_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_unidad_muldiv.sv
// ============================================================================
// tb_unidad_muldiv : directed self-checking bench for unidad_muldiv
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_unidad_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] datars1_i = 32'd0;
  logic [31:0] datars2_i = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        wren_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  unidad_muldiv #(.XLEN(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .op_i      (op_i),
    .datars1_i (datars1_i),
    .datars2_i (datars2_i),
    .rd_i      (rd_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .rd_o      (rd_o),
    .wren_o    (wren_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op; exp_lat counts rising edges from the accepting edge to done_o
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk_i);
    op_i = op; datars1_i = a; datars2_i = b; rd_i = rd; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; datars1_i = $urandom; datars2_i = $urandom; rd_i = ~rd;
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, result_o, exp);
    chk({tag, ".wren"}, {31'd0, wren_o}, 32'd1);
    chk({tag, ".rd"}, {27'd0, rd_o}, {27'd0, rd});
    @(posedge clk_i); #1;
    chk({tag, ".pulse"}, {31'd0, done_o}, 32'd0);
    chk({tag, ".hold"}, result_o, exp);
  endtask

  initial begin
    int ndone;
    int done_at;
    logic [31:0] res_seen;

    #1;
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.done", {31'd0, done_o}, 32'd0);
    chk("rst.wren", {31'd0, wren_o}, 32'd0);
    chk("rst.res", result_o, 32'd0);
    chk("rst.rd", {27'd0, rd_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    do_op("mul7x6",   3'd0, 32'd7,        32'd6,        5'd5,  32'd42,        32);
    do_op("mulh_m1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h0,         32);
    do_op("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE,  32);
    do_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF,  32);
    do_op("mul_lo",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'd1,         32);
    do_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000,  32);
    do_op("mulhsu_b", 3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000,  32);
    do_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD,  32);
    do_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF,  32);
    do_op("div_7_m2", 3'd4, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD,  32);
    do_op("rem_7_m2", 3'd6, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,         32);
    do_op("divu",     3'd5, 32'd100,      32'd7,        5'd16, 32'd14,        32);
    do_op("remu",     3'd7, 32'd100,      32'd7,        5'd17, 32'd2,         32);
    do_op("div_z",    3'd4, 32'd5,        32'd0,        5'd18, 32'hFFFFFFFF,  0);
    do_op("rem_z",    3'd6, 32'd5,        32'd0,        5'd19, 32'd5,         0);
    do_op("divu_z",   3'd5, 32'd5,        32'd0,        5'd20, 32'hFFFFFFFF,  0);
    do_op("remu_z",   3'd7, 32'd5,        32'd0,        5'd21, 32'd5,         0);
    do_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h80000000,  0);
    do_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'd0,         0);

    // Second start mid-operation must be ignored
    @(negedge clk_i);
    op_i = 3'd0; datars1_i = 32'd1000; datars2_i = 32'd1000; rd_i = 5'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    ndone = 0; done_at = 0; res_seen = 32'd0;
    for (int e = 1; e <= 36; e++) begin
      @(negedge clk_i);
      start_i = (e == 10);
      if (e == 10) begin datars1_i = 32'd2; datars2_i = 32'd2; op_i = 3'd0; end
      @(posedge clk_i); #1;
      if (done_o) begin ndone++; done_at = e; res_seen = result_o; end
    end
    start_i = 1'b0;
    chk("restart.count", ndone, 1);
    chk("restart.lat", done_at, 32);
    chk("restart.res", res_seen, 32'd1000000);

    // Reset in the middle of a DIVU
    @(negedge clk_i);
    op_i = 3'd5; datars1_i = 32'd1000; datars2_i = 32'd3; rd_i = 5'd27; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy_o}, 32'd0);
    chk("abort.done", {31'd0, done_o}, 32'd0);
    chk("abort.wren", {31'd0, wren_o}, 32'd0);
    chk("abort.res", result_o, 32'd0);
    chk("abort.rd", {27'd0, rd_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk_i); #1;
      if (done_o) ndone++;
    end
    chk("abort.nodone", ndone, 0);
    do_op("mul3x3", 3'd0, 32'd3, 32'd3, 5'd4, 32'd9, 32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
